stage_memory_unit: RTL and testbench
====================================

# stage_memory_unit

Memory-stage responder for the core's stage sequencer: it watches its own `stage_active` bit (the STAGE_MEMORY bit, index 5), performs at most one load or store on the core data bus per activation, and reports completion on its `stage_done` bit. It is the execution side of the sequencer handshake. It also handles byte/halfword lane steering, sign extension, misalignment detection and bus-timeout detection, so the sequencer never sees a stage that fails to finish.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles without `bus_ack` before an access is aborted with `bus_error`. Valid range is 1..255.
- `clk  in  1`: core clock. All logic is on its rising edge.
- `reset  in  1`: synchronous, active-high.
- `stage_active  in  1`: this stage's bit of the sequencer's one-hot active vector.
- `stage_done  out  1`: completion flag back to the sequencer. Registered.
- `mem_read  in  1`, `mem_write  in  1`: operation select. Both 0 means no memory op. Both 1 is illegal.
- `funct3  in  3`: size and sign. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr  in  32`: byte address.
- `wdata  in  32`: store data, right-justified.
- `rdata  out  32`: load result, extended to 32 bits. Registered.
- `misaligned  out  1`, `illegal_op  out  1`, `bus_error  out  1`: exception flags. Registered.
- `bus_req  out  1`, `bus_we  out  1`, `bus_addr  out  32` (bits [1:0]=0), `bus_wstrb  out  4`, `bus_wdata  out  32`: bus request side.
- `bus_ack  in  1`, `bus_rdata  in  32`: bus response side.

## Operation
- States are IDLE, ACCESS and DONE.
- **Reset.** State IDLE. All outputs are 0: `stage_done`, `bus_req`, `bus_we`, `bus_wstrb`, `bus_addr`, `bus_wdata`, `rdata`, all flags. The timeout counter is 0.
- **Inactive stage.** While `stage_active`=0, the unit is in IDLE and `stage_done` is forced to 0. This guarantees `stage_done` is 0 on the first active cycle. The sequencer ignores `stage_done` during its mandatory first stall cycle.
- **IDLE with `stage_active`=1.** Operand inputs are latched this cycle, then:
  - No op: go to DONE, `stage_done`=1.
  - Illegal op (`mem_read` and `mem_write` both 1, load `funct3` outside {000,001,010,100,101}, or store `funct3` outside {000,001,010}): set `illegal_op`, go to DONE.
  - Misaligned (H/HU with `addr[0]`=1, W with `addr[1:0]`≠0): set `misaligned`, go to DONE. No bus access is made.
  - Otherwise: drive the bus outputs, go to ACCESS, clear the timeout counter.
- **Bus drive on entry to ACCESS.**
  - `bus_addr` = `{addr[31:2],2'b00}`.
  - `bus_we` = `mem_write`.
  - `bus_wstrb`: B → 0001<<`addr[1:0]`; H → 0011<<`addr[1:0]`; W → 1111; loads → 0000.
  - `bus_wdata` = `wdata` replicated into the addressed lanes (byte ×4, half ×2).
- **ACCESS.**
  - `bus_req`=1 and all bus outputs are held stable until `bus_ack` is sampled 1.
  - On ack: drop `bus_req`. For a load, set `rdata` to the selected lane, sign-extended (B/H) or zero-extended (BU/HU). Set `stage_done`=1 and go to DONE.
  - No ack: increment the counter. When the counter reaches `TIMEOUT_CYCLES`, drop `bus_req`, set `bus_error`=1 and `stage_done`=1, leave `rdata` unchanged, and go to DONE.
- **DONE.** `stage_done`, `rdata` and the flags are held while `stage_active`=1. When `stage_active` falls, go to IDLE: `stage_done`→0 and flags→0. `rdata` is held until the next load completes, for write-back.
- **`stage_active` falls during ACCESS** (sequencer protocol violation): drop `bus_req` next cycle, go to IDLE, set no flags. A late `bus_ack` is ignored.
- **Reset during ACCESS:** `bus_req` is 0 the next cycle. The transaction is abandoned.
- **Ack in the same cycle `bus_req` first rises:** not possible. `bus_ack` is only sampled while `bus_req` is registered high.

## Timing
- Cycle 0 is the first cycle `stage_active`=1 is sampled.
- No-op, illegal or misaligned: `stage_done`=1 from cycle 1.
- Bus access: `bus_req`=1 from cycle 1. If ack is sampled in cycle k (k≥1), then `bus_req`=0, `stage_done`=1 and `rdata` is valid from cycle k+1. Zero-wait ack gives `stage_done` at cycle 2.
- Timeout: `bus_error` and `stage_done` from cycle `TIMEOUT_CYCLES`+1.
- `stage_done` falls the cycle after `stage_active` falls. It is never high in a cycle where it was 0 in the previous cycle and `stage_active` was 0.

## Structure
- Shared `core_pkg` holds:
  - stage index constants (STAGE_CONTROL..STAGE_WRITE_BACK, NUM_STAGES=7);
  - `funct3` load/store encodings;
  - the `mem_state_t` enum (IDLE/ACCESS/DONE).
- One combinational sub-module, `mem_lane_align`, handles strobe generation, write-data replication and load extraction/extension. The unit has a 8-bit timeout counter.

## Test plan
- **Zero-wait LW.** `addr`=0x1004, `bus_rdata`=0xDEADBEEF, ack at cycle 1 → `bus_addr`=0x1004, `bus_wstrb`=0000, `stage_done`=1 at cycle 2, `rdata`=0xDEADBEEF.
- **LB with sign extension.** `addr`=0x2003, `bus_rdata`=0x80112233 → `rdata`=0xFFFFFF80. Repeat as LBU → `rdata`=0x00000080.
- **SH with wait states.** `addr`=0x3002, `wdata`=0x0000ABCD, ack delayed 3 cycles → `bus_wstrb`=1100, `bus_wdata`=0xABCDABCD, `bus_req` held 4 cycles, `stage_done` at cycle 5.
- **Misaligned LW.** `addr`=0x4001 → `misaligned`=1 and `stage_done`=1 at cycle 1, `bus_req` never rises. Flags clear the cycle after `stage_active` falls.
- **Timeout.** `TIMEOUT_CYCLES`=4, no ack → `bus_error`=1 and `stage_done`=1 at cycle 5, `bus_req`=0 from cycle 5.
- **Reset and abort mid-ACCESS.** Assert `reset` at cycle 2 of a pending load → all outputs 0 at cycle 3. Separately, drop `stage_active` mid-ACCESS → `bus_req`=0 next cycle, no flags set.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: sequencer stage indices, funct3 memory
// encodings and the memory-stage state type.
package core_pkg;

   localparam int STAGE_CONTROL    = 0;
   localparam int STAGE_FETCH      = 1;
   localparam int STAGE_DECODE     = 2;
   localparam int STAGE_REGISTER   = 3;
   localparam int STAGE_EXECUTE    = 4;
   localparam int STAGE_MEMORY     = 5;
   localparam int STAGE_WRITE_BACK = 6;
   localparam int NUM_STAGES       = 7;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } mem_state_t;

   function automatic logic load_ok(input logic [2:0] f3);
      return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
   endfunction

   function automatic logic store_ok(input logic [2:0] f3);
      return f3 inside {F3_B, F3_H, F3_W};
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3,
                                          input logic [1:0] off);
      logic half;
      logic word;
      half = (f3 == F3_H) || (f3 == F3_HU);
      word = (f3 == F3_W);
      return (half && off[0]) || (word && (off != 2'b00));
   endfunction

endpackage

// File: rtl/stage_memory_unit_if.sv
// Core data bus: one request/acknowledge channel, word addressed with
// byte strobes.
interface stage_memory_unit_if;

   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
      output bus_ack, bus_rdata
   );

endinterface

// File: rtl/stage_memory_unit_align.sv
// Byte-lane steering: store strobes and data replication, load lane
// extraction with sign or zero extension.
module mem_lane_align
   import core_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] bus_rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata_rep,
   output logic [31:0] load_data
);

   logic [31:0] shifted;
   logic [7:0]  b;
   logic [15:0] h;

   assign shifted = bus_rdata >> {offset, 3'b000};
   assign b       = shifted[7:0];
   assign h       = offset[1] ? bus_rdata[31:16] : bus_rdata[15:0];

   always_comb begin
      wstrb     = 4'b0000;
      wdata_rep = wdata;
      load_data = bus_rdata;
      unique case (funct3)
         F3_B: begin
            wstrb     = 4'b0001 << offset;
            wdata_rep = {4{wdata[7:0]}};
            load_data = {{24{b[7]}}, b};
         end
         F3_H: begin
            wstrb     = 4'b0011 << offset;
            wdata_rep = {2{wdata[15:0]}};
            load_data = {{16{h[15]}}, h};
         end
         F3_W: begin
            wstrb     = 4'b1111;
         end
         F3_BU: load_data = {24'h0, b};
         F3_HU: load_data = {16'h0, h};
         default: ;
      endcase
   end

endmodule

// File: rtl/stage_memory_unit.sv
// Memory-stage responder: one load/store per activation of its
// sequencer bit, with alignment checks and bus timeout.
module stage_memory_unit
   import core_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stage_active,
   output logic        stage_done,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        misaligned,
   output logic        illegal_op,
   output logic        bus_error,
   stage_memory_unit_if.master bus
);

   mem_state_t  state;
   logic [7:0]  cnt;
   logic [8:0]  cnt_nxt;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;

   logic        req_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [3:0]  wstrb_q;
   logic [31:0] wdata_q;

   logic [2:0]  sel_f3;
   logic [1:0]  sel_off;
   logic [3:0]  al_wstrb;
   logic [31:0] al_wdata;
   logic [31:0] al_load;

   logic        no_op;
   logic        illegal;
   logic        mis;

   assign no_op   = !mem_read && !mem_write;
   assign illegal = (mem_read && mem_write)
                 || (mem_read && !load_ok(funct3))
                 || (mem_write && !store_ok(funct3));
   assign mis     = is_misaligned(funct3, addr[1:0]);
   assign cnt_nxt = {1'b0, cnt} + 9'd1;

   // Decode live operands while idle, the latched ones during the access.
   assign sel_f3  = (state == IDLE) ? funct3    : f3_q;
   assign sel_off = (state == IDLE) ? addr[1:0] : off_q;

   mem_lane_align u_align (
      .funct3    (sel_f3),
      .offset    (sel_off),
      .wdata     (wdata),
      .bus_rdata (bus.bus_rdata),
      .wstrb     (al_wstrb),
      .wdata_rep (al_wdata),
      .load_data (al_load)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         f3_q       <= '0;
         off_q      <= '0;
         stage_done <= 1'b0;
         rdata      <= '0;
         misaligned <= 1'b0;
         illegal_op <= 1'b0;
         bus_error  <= 1'b0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wstrb_q    <= '0;
         wdata_q    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               stage_done <= 1'b0;
               if (stage_active) begin
                  f3_q  <= funct3;
                  off_q <= addr[1:0];
                  if (no_op) begin
                     stage_done <= 1'b1;
                     state      <= DONE;
                  end else if (illegal) begin
                     illegal_op <= 1'b1;
                     stage_done <= 1'b1;
                     state      <= DONE;
                  end else if (mis) begin
                     misaligned <= 1'b1;
                     stage_done <= 1'b1;
                     state      <= DONE;
                  end else begin
                     req_q   <= 1'b1;
                     we_q    <= mem_write;
                     addr_q  <= {addr[31:2], 2'b00};
                     wstrb_q <= mem_write ? al_wstrb : 4'b0000;
                     wdata_q <= al_wdata;
                     cnt     <= '0;
                     state   <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (!stage_active) begin
                  req_q <= 1'b0;
                  state <= IDLE;
               end else if (bus.bus_ack) begin
                  req_q      <= 1'b0;
                  stage_done <= 1'b1;
                  if (!we_q) rdata <= al_load;
                  state      <= DONE;
               end else if (cnt_nxt == 9'(TIMEOUT_CYCLES)) begin
                  req_q      <= 1'b0;
                  bus_error  <= 1'b1;
                  stage_done <= 1'b1;
                  state      <= DONE;
               end else begin
                  cnt <= cnt_nxt[7:0];
               end
            end
            DONE: begin
               if (!stage_active) begin
                  stage_done <= 1'b0;
                  misaligned <= 1'b0;
                  illegal_op <= 1'b0;
                  bus_error  <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.bus_req   = req_q;
   assign bus.bus_we    = we_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_wstrb = wstrb_q;
   assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_stage_memory_unit.sv
// Directed bench for stage_memory_unit with a 4-cycle bus timeout.
module tb_stage_memory_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stage_active;
   logic        stage_done;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        misaligned;
   logic        illegal_op;
   logic        bus_error;

   int errors = 0;
   int checks = 0;

   stage_memory_unit_if bus_if ();

   stage_memory_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .stage_active (stage_active),
      .stage_done   (stage_done),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .funct3       (funct3),
      .addr         (addr),
      .wdata        (wdata),
      .rdata        (rdata),
      .misaligned   (misaligned),
      .illegal_op   (illegal_op),
      .bus_error    (bus_error),
      .bus          (bus_if)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
      mem_read     = rd;
      mem_write    = wr;
      funct3       = f3;
      addr         = a;
      wdata        = wd;
      stage_active = 1'b1;
   endtask

   task automatic finish_op(input string nm);
      stage_active = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      step();
      checks++;
      if ({stage_done, misaligned, illegal_op, bus_error, bus_if.bus_req} !== 5'b0) begin
         errors++;
         $display("FAIL %s_release: done/mis/ill/err/req=%b want 00000", nm,
                  {stage_done, misaligned, illegal_op, bus_error, bus_if.bus_req});
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      stage_active = 1'b0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      funct3 = 3'b000;
      addr = '0;
      wdata = '0;
      bus_if.bus_ack = 1'b0;
      bus_if.bus_rdata = '0;
      step();
      step();
      checks++;
      if ({stage_done, rdata, misaligned, illegal_op, bus_error, bus_if.bus_req,
           bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wstrb, bus_if.bus_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: done=%b rdata=%h req=%b addr=%h want all 0",
                  stage_done, rdata, bus_if.bus_req, bus_if.bus_addr);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_lw_zero_wait();
      bus_if.bus_rdata = 32'hDEADBEEF;
      start(1'b1, 1'b0, 3'b010, 32'h0000_1004, 32'h0);
      checks++;
      if (stage_done !== 1'b0) begin
         errors++; $display("FAIL lw_done_c0: got %b want 0", stage_done);
      end
      step();
      checks++;
      if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wstrb}
          !== {1'b1, 1'b0, 32'h0000_1004, 4'b0000}) begin
         errors++;
         $display("FAIL lw_bus_c1: req=%b we=%b addr=%h strb=%b want 1 0 00001004 0000",
                  bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wstrb);
      end
      checks++;
      if (stage_done !== 1'b0) begin
         errors++; $display("FAIL lw_done_c1: got %b want 0", stage_done);
      end
      bus_if.bus_ack = 1'b1;
      step();
      bus_if.bus_ack = 1'b0;
      checks++;
      if ({stage_done, bus_if.bus_req, rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL lw_done_c2: done=%b req=%b rdata=%h want 1 0 deadbeef",
                  stage_done, bus_if.bus_req, rdata);
      end
      step();
      checks++;
      if ({stage_done, rdata} !== {1'b1, 32'hDEADBEEF}) begin
         errors++; $display("FAIL lw_hold: done=%b rdata=%h want 1 deadbeef", stage_done, rdata);
      end
      finish_op("lw");
   endtask

   task automatic load_ack1(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] bd, input logic [31:0] exp,
                            input string nm);
      bus_if.bus_rdata = bd;
      start(1'b1, 1'b0, f3, a, 32'h0);
      step();
      checks++;
      if ({bus_if.bus_req, bus_if.bus_addr} !== {1'b1, a[31:2], 2'b00}) begin
         errors++;
         $display("FAIL %s_req: req=%b addr=%h want 1 %h", nm, bus_if.bus_req,
                  bus_if.bus_addr, {a[31:2], 2'b00});
      end
      bus_if.bus_ack = 1'b1;
      step();
      bus_if.bus_ack = 1'b0;
      checks++;
      if ({stage_done, rdata} !== {1'b1, exp}) begin
         errors++; $display("FAIL %s_rdata: done=%b rdata=%h want 1 %h", nm, stage_done, rdata, exp);
      end
      finish_op(nm);
   endtask

   task automatic test_load_extend();
      load_ack1(3'b000, 32'h0000_2003, 32'h80112233, 32'hFFFFFF80, "lb");
      load_ack1(3'b001, 32'h0000_9002, 32'hF00D1234, 32'hFFFFF00D, "lh");
      load_ack1(3'b101, 32'h0000_9002, 32'hF00D1234, 32'h0000F00D, "lhu");
      load_ack1(3'b100, 32'h0000_2003, 32'h80112233, 32'h00000080, "lbu");
   endtask

   task automatic test_sh_wait();
      start(1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'h0000ABCD);
      for (int c = 1; c <= 4; c++) begin
         step();
         checks++;
         if ({bus_if.bus_req, stage_done} !== 2'b10) begin
            errors++; $display("FAIL sh_req_c%0d: req/done=%b want 10", c, {bus_if.bus_req, stage_done});
         end
         if (c == 1) begin
            checks++;
            if ({bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wstrb, bus_if.bus_wdata}
                !== {1'b1, 32'h0000_3000, 4'b1100, 32'hABCDABCD}) begin
               errors++;
               $display("FAIL sh_bus: we=%b addr=%h strb=%b wdata=%h want 1 00003000 1100 abcdabcd",
                        bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wstrb, bus_if.bus_wdata);
            end
         end
      end
      checks++;
      if (bus_if.bus_wdata !== 32'hABCDABCD) begin
         errors++; $display("FAIL sh_hold: wdata=%h want abcdabcd", bus_if.bus_wdata);
      end
      bus_if.bus_ack = 1'b1;
      step();
      bus_if.bus_ack = 1'b0;
      checks++;
      if ({stage_done, bus_if.bus_req, rdata} !== {1'b1, 1'b0, 32'h00000080}) begin
         errors++;
         $display("FAIL sh_done_c5: done=%b req=%b rdata=%h want 1 0 00000080",
                  stage_done, bus_if.bus_req, rdata);
      end
      finish_op("sh");
   endtask

   task automatic test_sb();
      start(1'b0, 1'b1, 3'b000, 32'h0000_8001, 32'h123456A5);
      step();
      checks++;
      if ({bus_if.bus_wstrb, bus_if.bus_wdata} !== {4'b0010, 32'hA5A5A5A5}) begin
         errors++;
         $display("FAIL sb_bus: strb=%b wdata=%h want 0010 a5a5a5a5", bus_if.bus_wstrb, bus_if.bus_wdata);
      end
      bus_if.bus_ack = 1'b1;
      step();
      bus_if.bus_ack = 1'b0;
      checks++;
      if (stage_done !== 1'b1) begin
         errors++; $display("FAIL sb_done: got %b want 1", stage_done);
      end
      finish_op("sb");
   endtask

   task automatic test_misaligned();
      start(1'b1, 1'b0, 3'b010, 32'h0000_4001, 32'h0);
      for (int c = 1; c <= 2; c++) begin
         step();
         checks++;
         if ({misaligned, stage_done, bus_if.bus_req, illegal_op} !== 4'b1100) begin
            errors++;
            $display("FAIL mis_c%0d: mis/done/req/ill=%b want 1100", c,
                     {misaligned, stage_done, bus_if.bus_req, illegal_op});
         end
      end
      finish_op("mis");
   endtask

   task automatic test_illegal_noop();
      start(1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0);
      step();
      checks++;
      if ({illegal_op, stage_done, bus_if.bus_req} !== 3'b110) begin
         errors++; $display("FAIL ill_rw: ill/done/req=%b want 110", {illegal_op, stage_done, bus_if.bus_req});
      end
      finish_op("ill_rw");
      start(1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0);
      step();
      checks++;
      if ({illegal_op, stage_done, bus_if.bus_req} !== 3'b110) begin
         errors++; $display("FAIL ill_sbu: ill/done/req=%b want 110", {illegal_op, stage_done, bus_if.bus_req});
      end
      finish_op("ill_sbu");
      start(1'b0, 1'b0, 3'b000, 32'h0000_0000, 32'h0);
      step();
      checks++;
      if ({stage_done, illegal_op, misaligned, bus_if.bus_req} !== 4'b1000) begin
         errors++;
         $display("FAIL noop: done/ill/mis/req=%b want 1000", {stage_done, illegal_op, misaligned, bus_if.bus_req});
      end
      finish_op("noop");
   endtask

   task automatic test_timeout();
      start(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0);
      for (int c = 1; c <= 4; c++) begin
         step();
         checks++;
         if ({bus_if.bus_req, stage_done, bus_error} !== 3'b100) begin
            errors++;
            $display("FAIL tmo_c%0d: req/done/err=%b want 100", c, {bus_if.bus_req, stage_done, bus_error});
         end
      end
      step();
      checks++;
      if ({bus_if.bus_req, stage_done, bus_error, rdata} !== {3'b011, 32'h00000080}) begin
         errors++;
         $display("FAIL tmo_c5: req/done/err=%b rdata=%h want 011 00000080",
                  {bus_if.bus_req, stage_done, bus_error}, rdata);
      end
      finish_op("tmo");
   endtask

   task automatic test_reset_mid_access();
      start(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0);
      step();
      step();
      checks++;
      if (bus_if.bus_req !== 1'b1) begin
         errors++; $display("FAIL rst_pending: req=%b want 1", bus_if.bus_req);
      end
      reset = 1'b1;
      step();
      checks++;
      if ({stage_done, rdata, misaligned, illegal_op, bus_error, bus_if.bus_req,
           bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wstrb, bus_if.bus_wdata} !== '0) begin
         errors++;
         $display("FAIL rst_mid: done=%b rdata=%h req=%b addr=%h want all 0",
                  stage_done, rdata, bus_if.bus_req, bus_if.bus_addr);
      end
      reset = 1'b0;
      stage_active = 1'b0;
      mem_read = 1'b0;
      step();
   endtask

   task automatic test_abort();
      start(1'b1, 1'b0, 3'b001, 32'h0000_7002, 32'h0);
      step();
      checks++;
      if (bus_if.bus_req !== 1'b1) begin
         errors++; $display("FAIL abort_req: req=%b want 1", bus_if.bus_req);
      end
      stage_active = 1'b0;
      step();
      checks++;
      if ({bus_if.bus_req, stage_done, misaligned, illegal_op, bus_error} !== 5'b0) begin
         errors++;
         $display("FAIL abort_drop: req/done/flags=%b want 00000",
                  {bus_if.bus_req, stage_done, misaligned, illegal_op, bus_error});
      end
      bus_if.bus_ack = 1'b1;
      step();
      bus_if.bus_ack = 1'b0;
      checks++;
      if ({bus_if.bus_req, stage_done, rdata} !== {2'b00, 32'h0}) begin
         errors++;
         $display("FAIL abort_late_ack: req=%b done=%b rdata=%h want 0 0 0",
                  bus_if.bus_req, stage_done, rdata);
      end
   endtask

   initial begin
      test_reset();
      test_lw_zero_wait();
      test_load_extend();
      test_sh_wait();
      test_sb();
      test_misaligned();
      test_illegal_noop();
      test_timeout();
      test_reset_mid_access();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
